// File: rtl/and_bus_monitor_if.sv
// Bundle of the stimulus, netlist-output and result-handshake signals seen by and_bus_monitor.
// The master side drives the netlist samples and consumes the counters.
interface and_bus_monitor_if #(
    parameter int CNT_W = 8
) ();
    logic             start;
    logic             in_valid;
    logic             d;
    logic             y0;
    logic             y1;
    logic             y2;
    logic             busy;
    logic [CNT_W-1:0] err_gnd;
    logic [CNT_W-1:0] err_vcc;
    logic [CNT_W-1:0] y2_ones;
    logic             sticky_fail;
    logic             res_valid;
    logic             res_ready;

    modport master (
        output start, in_valid, d, y0, y1, y2, res_ready,
        input  busy, err_gnd, err_vcc, y2_ones, sticky_fail, res_valid
    );

    modport slave (
        input  start, in_valid, d, y0, y1, y2, res_ready,
        output busy, err_gnd, err_vcc, y2_ones, sticky_fail, res_valid
    );
endinterface

// File: rtl/and_bus_monitor.sv
// Windowed checker for the tie-cell AND netlist: counts y0!=0 and y1!=d violations plus y2 ones
// over WINDOW valid samples and hands the totals out through a valid/ready result.
module and_bus_monitor #(
    parameter int WINDOW = 16,
    parameter int CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    and_bus_monitor_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ARM, RUN, REPORT} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WINDOW - 1);

    state_t                  state_reg;
    logic                    s_valid_reg;
    logic                    s_d_reg;
    logic                    s_y0_reg;
    logic                    s_y1_reg;
    logic                    s_y2_reg;
    logic [CNT_W-1:0]        sample_cnt_reg;
    logic                    sticky_reg;
    logic                    count_en;
    logic [2:0]              inc;
    logic [2:0][CNT_W-1:0]   cnt_all;

    // Capture stage runs in every state; only RUN consumes what it holds.
    always_ff @(posedge clk) begin
        if (rst) begin
            s_valid_reg <= 1'b0;
            s_d_reg     <= 1'b0;
            s_y0_reg    <= 1'b0;
            s_y1_reg    <= 1'b0;
            s_y2_reg    <= 1'b0;
        end else begin
            s_valid_reg <= bus.in_valid;
            s_d_reg     <= bus.d;
            s_y0_reg    <= bus.y0;
            s_y1_reg    <= bus.y1;
            s_y2_reg    <= bus.y2;
        end
    end

    assign count_en = (state_reg == RUN) && s_valid_reg;
    assign inc      = {s_y2_reg, s_y1_reg ^ s_d_reg, s_y0_reg};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            sample_cnt_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.start) begin
                        state_reg <= ARM;
                    end
                end
                ARM: begin
                    sample_cnt_reg <= '0;
                    state_reg      <= RUN;
                end
                RUN: begin
                    if (s_valid_reg) begin
                        sample_cnt_reg <= sample_cnt_reg + 1'b1;
                        if (sample_cnt_reg == LAST_IDX) begin
                            state_reg <= REPORT;
                        end
                    end
                end
                REPORT: begin
                    if (bus.res_ready) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // err_gnd, err_vcc, y2_ones share one saturating counter shape, indexed by inc bit.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
            logic [CNT_W-1:0] cnt_reg;

            always_ff @(posedge clk) begin
                if (rst) begin
                    cnt_reg <= '0;
                end else if (state_reg == ARM) begin
                    cnt_reg <= '0;
                end else if (count_en && inc[gi] && (cnt_reg != CNT_MAX)) begin
                    cnt_reg <= cnt_reg + 1'b1;
                end
            end

            assign cnt_all[gi] = cnt_reg;
        end
    endgenerate

    // Any counted error makes an error counter nonzero on this same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            sticky_reg <= 1'b0;
        end else if (state_reg == ARM) begin
            sticky_reg <= 1'b0;
        end else if (count_en && (inc[0] || inc[1])) begin
            sticky_reg <= 1'b1;
        end
    end

    assign bus.busy        = (state_reg != IDLE);
    assign bus.res_valid   = (state_reg == REPORT);
    assign bus.err_gnd     = cnt_all[0];
    assign bus.err_vcc     = cnt_all[1];
    assign bus.y2_ones     = cnt_all[2];
    assign bus.sticky_fail = sticky_reg;
endmodule

// File: tb/tb_and_bus_monitor.sv
// Directed bench for and_bus_monitor: a WINDOW=16/CNT_W=8 instance for the main runs and a
// WINDOW=15/CNT_W=4 instance for saturation, with hand-computed expected totals.
module tb_and_bus_monitor;
    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    and_bus_monitor_if #(.CNT_W(8)) bus ();
    and_bus_monitor_if #(.CNT_W(4)) sbus ();

    and_bus_monitor #(.WINDOW(16), .CNT_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    and_bus_monitor #(.WINDOW(15), .CNT_W(4)) dut_sat (
        .clk (clk),
        .rst (rst),
        .bus (sbus)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv)
        else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic idle_inputs();
        bus.start = 0; bus.in_valid = 0; bus.d = 0; bus.y0 = 0; bus.y1 = 0; bus.y2 = 0;
        bus.res_ready = 0;
        sbus.start = 0; sbus.in_valid = 0; sbus.d = 0; sbus.y0 = 0; sbus.y1 = 0; sbus.y2 = 0;
        sbus.res_ready = 0;
    endtask

    task automatic chk_counts(input string tag, input int eg, input int ev, input int ey,
                              input logic es);
        chk({tag, "_err_gnd"}, bus.err_gnd, eg);
        chk({tag, "_err_vcc"}, bus.err_vcc, ev);
        chk({tag, "_y2_ones"}, bus.y2_ones, ey);
        chk({tag, "_sticky"}, bus.sticky_fail, es);
    endtask

    task automatic pulse_reset();
        idle_inputs();
        rst = 1;
        step();
        rst = 0;
    endtask

    // One 16-sample run on the main instance. Sample i: d=i[0], y0=y0v[i], y1=d^flip[i], y2=y2v[i].
    task automatic run16(input string tag, input logic [15:0] y0v, input logic [15:0] flip,
                         input logic [15:0] y2v, input int gap, input int holdoff,
                         input int start_at, input int eg, input int ev, input int ey,
                         input logic es);
        logic [15:0] errm;
        errm = y0v | flip;
        bus.start = 1;
        step();
        bus.start = 0;
        chk({tag, "_arm_busy"}, bus.busy, 1);
        for (int i = 0; i < 16; i++) begin
            bus.in_valid = 1;
            bus.d        = i[0];
            bus.y0       = y0v[i];
            bus.y1       = i[0] ^ flip[i];
            bus.y2       = y2v[i];
            bus.start    = (i == start_at);
            step();
            bus.start = 0;
            // Here samples 0..i-1 are reflected in the outputs.
            chk({tag, "_sticky_run"}, bus.sticky_fail, |(errm & ((16'd1 << i) - 16'd1)));
            chk({tag, "_res_valid_run"}, bus.res_valid, 0);
            if (i == 0) begin
                chk({tag, "_armclr_gnd"}, bus.err_gnd, 0);
                chk({tag, "_armclr_vcc"}, bus.err_vcc, 0);
            end
            if (i < 15) begin
                for (int k = 1; k < gap; k++) begin
                    bus.in_valid = 0; bus.y0 = 1; bus.y1 = ~bus.d; bus.y2 = 1;
                    step();
                end
            end
        end
        // Junk presented while in REPORT must not be counted.
        bus.in_valid = 1; bus.d = 1; bus.y0 = 1; bus.y1 = 0; bus.y2 = 1;
        step();
        for (int h = 0; h < holdoff; h++) begin
            chk({tag, "_hold_res_valid"}, bus.res_valid, 1);
            chk_counts({tag, "_hold"}, eg, ev, ey, es);
            step();
        end
        chk({tag, "_res_valid"}, bus.res_valid, 1);
        chk_counts({tag, "_report"}, eg, ev, ey, es);
        bus.res_ready = 1;
        step();
        idle_inputs();
        chk({tag, "_after_hs_valid"}, bus.res_valid, 0);
        chk({tag, "_after_hs_busy"}, bus.busy, 0);
        chk_counts({tag, "_held"}, eg, ev, ey, es);
        $display("run %s: err_gnd=%0d err_vcc=%0d y2_ones=%0d sticky=%0d", tag,
                 bus.err_gnd, bus.err_vcc, bus.y2_ones, bus.sticky_fail);
    endtask

    initial begin
        int seen_valid;
        idle_inputs();
        rst = 1;
        bus.in_valid = 1; bus.y0 = 1;
        step();
        step();
        rst = 0;
        for (int i = 0; i < 4; i++) step();
        chk("idle_busy", bus.busy, 0);
        chk("idle_res_valid", bus.res_valid, 0);
        chk_counts("idle", 0, 0, 0, 0);
        chk("idle_sat_busy", sbus.busy, 0);
        chk("idle_sat_gnd", sbus.err_gnd, 0);
        idle_inputs();
        step();

        run16("clean", 16'h0000, 16'h0000, 16'h0000, 1, 0, -1, 0, 0, 0, 1'b0);
        run16("fault", 16'h0044, 16'h0010, 16'h8221, 1, 0, -1, 2, 1, 4, 1'b1);
        run16("gappy", 16'h0000, 16'h0000, 16'hFFFF, 3, 5, -1, 0, 0, 16, 1'b0);
        run16("restart", 16'h0000, 16'h00FF, 16'h0000, 1, 2, 10, 0, 8, 0, 1'b1);

        // Abort: reset after 6 faulty samples have been counted.
        pulse_reset();
        bus.start = 1;
        step();
        bus.start = 0;
        for (int i = 0; i < 8; i++) begin
            bus.in_valid = 1; bus.d = i[0]; bus.y1 = i[0]; bus.y0 = (i < 6); bus.y2 = 0;
            step();
        end
        chk("abort_pre_gnd", bus.err_gnd, 6);
        chk("abort_pre_sticky", bus.sticky_fail, 1);
        rst = 1;
        step();
        rst = 0;
        chk("abort_busy", bus.busy, 0);
        chk("abort_res_valid", bus.res_valid, 0);
        chk_counts("abort", 0, 0, 0, 0);
        seen_valid = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (bus.res_valid === 1'b1) seen_valid++;
        end
        chk("abort_no_result", seen_valid, 0);
        $display("run abort: err_gnd=%0d res_valid_cycles=%0d", bus.err_gnd, seen_valid);
        idle_inputs();
        step();

        // Saturation instance: 15 samples all y0=1, then 15 samples all y1!=d.
        sbus.start = 1;
        step();
        sbus.start = 0;
        for (int i = 0; i < 15; i++) begin
            sbus.in_valid = 1; sbus.d = i[0]; sbus.y0 = 1; sbus.y1 = i[0]; sbus.y2 = 0;
            step();
        end
        sbus.in_valid = 0;
        step();
        chk("sat1_res_valid", sbus.res_valid, 1);
        chk("sat1_err_gnd", sbus.err_gnd, 15);
        chk("sat1_err_vcc", sbus.err_vcc, 0);
        chk("sat1_sticky", sbus.sticky_fail, 1);
        $display("run sat1: err_gnd=%0d err_vcc=%0d", sbus.err_gnd, sbus.err_vcc);
        sbus.res_ready = 1;
        step();
        sbus.res_ready = 0;
        chk("sat1_after_hs", sbus.res_valid, 0);
        sbus.start = 1;
        step();
        sbus.start = 0;
        for (int i = 0; i < 15; i++) begin
            sbus.in_valid = 1; sbus.d = i[0]; sbus.y0 = 0; sbus.y1 = ~i[0]; sbus.y2 = 0;
            step();
            if (i == 0) chk("sat2_armclr_gnd", sbus.err_gnd, 0);
        end
        sbus.in_valid = 0;
        step();
        chk("sat2_res_valid", sbus.res_valid, 1);
        chk("sat2_err_vcc", sbus.err_vcc, 15);
        chk("sat2_err_gnd", sbus.err_gnd, 0);
        chk("sat2_y2_ones", sbus.y2_ones, 0);
        $display("run sat2: err_gnd=%0d err_vcc=%0d", sbus.err_gnd, sbus.err_vcc);
        sbus.res_ready = 1;
        step();
        sbus.res_ready = 0;
        chk("sat2_after_hs", sbus.res_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
